mem_access_unit: RTL

MEM-stage load/store unit sitting downstream of the EX/MEM pipeline register. It turns the registered memory-control fields (read/write strobes, size codes, ALU address, store data) into single-outstanding req/ack transactions on the data-memory bus, formats returned load data, and holds the pipeline with a stall until each access completes.

---
 rtl/mem_pkg.sv | 55 +++++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and encodings for the MEM-stage load/store unit.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [2:0] WR_BYTE = 3'b001;
    localparam logic [2:0] WR_HALF = 3'b010;
    localparam logic [2:0] WR_WORD = 3'b100;

    localparam logic [1:0] RD_WORD = 2'b00;
    localparam logic [1:0] RD_HALF = 2'b01;
    localparam logic [1:0] RD_BYTE = 2'b10;
    localparam logic [1:0] RD_RSVD = 2'b11;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_ALL     = 4'b1111;

    // Store size from the one-hot strobe; anything unexpected is treated as a word.
    function automatic size_t wr_size(input logic [2:0] bits);
        if (bits == WR_BYTE)      return SZ_BYTE;
        else if (bits == WR_HALF) return SZ_HALF;
        else                      return SZ_WORD;
    endfunction

    // Load size; the reserved code behaves like a word access.
    function automatic size_t rd_size(input logic [1:0] bits);
        case (bits)
            RD_BYTE: return SZ_BYTE;
            RD_HALF: return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // An access is misaligned when its low address bits do not fit the size.
    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return |lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables and replication, load lane extract/extend.
module mem_lane_align
    import mem_pkg::*;
(
    input  size_t       st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  size_t       ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Build enables and replicate the store data so every legal lane sees it.
    always_comb begin
        st_be   = BE_ALL;
        st_data = st_wdata;
        case (st_size)
            SZ_BYTE: begin
                st_be   = BE_BYTE0 << st_lo;
                st_data = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be   = st_lo[1] ? BE_HI_HALF : BE_LO_HALF;
                st_data = {2{st_wdata[15:0]}};
            end
            default: begin
                st_be   = BE_ALL;
                st_data = st_wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and sign- or zero-extend it.
    always_comb begin
        ld_byte = ld_rdata[{ld_lo, 3'b000} +: 8];
        ld_half = ld_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data = ld_rdata;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: single-outstanding req/ack bus master with pipeline stall.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_wr_bits,
    input  logic [1:0]  ex_rd_bits,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data,
    output logic        mem_stall,
    output logic        misalign
);

    state_t      state;
    state_t      state_next;
    logic        access;
    size_t       cur_size;
    logic        bad_align;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] ld_fmt;
    size_t       ld_size_q;
    logic [1:0]  ld_lo_q;
    logic        ld_uns_q;

    // A store wins over a load when both strobes are set, so its size decides alignment.
    assign access    = ex_mem_read | ex_mem_write;
    assign cur_size  = ex_mem_write ? wr_size(ex_wr_bits) : rd_size(ex_rd_bits);
    assign bad_align = is_misaligned(cur_size, ex_addr[1:0]);

    mem_lane_align u_align (
        .st_size     (wr_size(ex_wr_bits)),
        .st_lo       (ex_addr[1:0]),
        .st_wdata    (ex_wdata),
        .st_be       (st_be),
        .st_data     (st_data),
        .ld_size     (ld_size_q),
        .ld_lo       (ld_lo_q),
        .ld_unsigned (ld_uns_q),
        .ld_rdata    (bus_rdata),
        .ld_data     (ld_fmt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state, request, stall and misalign decode; DONE always drops back to IDLE.
    always_comb begin
        state_next = state;
        bus_req    = 1'b0;
        mem_stall  = 1'b0;
        misalign   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    if (bad_align) begin
                        misalign = 1'b1;
                    end else begin
                        mem_stall  = 1'b1;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                bus_req   = 1'b1;
                mem_stall = 1'b1;
                if (bus_ack) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Latch the bus fields and load formatting info when a request is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'h0;
            bus_wdata <= 32'h0;
            ld_size_q <= SZ_WORD;
            ld_lo_q   <= 2'b00;
            ld_uns_q  <= 1'b0;
        end else if (state == ST_IDLE && state_next == ST_REQ) begin
            bus_we    <= ex_mem_write;
            bus_addr  <= {ex_addr[31:2], 2'b00};
            bus_be    <= ex_mem_write ? st_be : BE_ALL;
            bus_wdata <= ex_mem_write ? st_data : 32'h0;
            ld_size_q <= rd_size(ex_rd_bits);
            ld_lo_q   <= ex_addr[1:0];
            ld_uns_q  <= ex_unsigned;
        end
    end

    // Load result updates only when a read completes and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst)                                      load_data <= 32'h0;
        else if (state == ST_REQ && bus_ack && !bus_we) load_data <= ld_fmt;
    end

endmodule
